// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RUN     = 2'd2
  } dma_state_t;

  localparam int          DMA_LEN_DEFAULT = 160;
  localparam logic [15:0] REG_FF46        = 16'hFF46;
  localparam logic [7:0]  ECHO_BASE       = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET     = 8'h20;
  localparam logic [7:0]  VRAM_LO         = 8'h80;
  localparam logic [7:0]  VRAM_HI         = 8'h9F;

  // Echo RAM (E000-FFFF) mirrors work RAM 0x2000 lower.
  function automatic logic [7:0] echo_remap(input logic [7:0] hi);
    echo_remap = (hi >= ECHO_BASE) ? (hi - ECHO_OFFSET) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_addr.sv
// Source high-byte remap (echo mirror) and VRAM source decode.
module oam_dma_addr
  import oam_dma_pkg::*;
(
  input  logic [7:0] src_hi,
  output logic [7:0] hi_map,
  output logic       hi_vram
);

  // Pure combinational remap and range decode of the mapped high byte.
  always_comb begin
    hi_map  = echo_remap(src_hi);
    hi_vram = (hi_map >= VRAM_LO) && (hi_map <= VRAM_HI);
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA controller: FF46 write launches a DMA_LEN-byte copy into OAM,
// one byte per M-cycle, after a single M-cycle startup delay.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int          DMA_LEN  = DMA_LEN_DEFAULT,
  parameter logic [15:0] REG_ADDR = REG_FF46
)(
  input  logic        clk,
  input  logic        nreset,
  input  logic        m_tick,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  reg_q,
  output logic        reg_rd_en,
  output logic        dma_run,
  output logic        vram_to_oam,
  output logic        oam_addr_ndma,
  output logic [15:0] dma_a,
  output logic        dma_oam_wr
);

  localparam logic [7:0] LAST_LO = 8'(DMA_LEN - 1);

  dma_state_t state, state_nxt;
  logic [7:0] src_hi, src_hi_nxt;
  logic [7:0] lo, lo_nxt;
  logic [7:0] dma_hi, dma_hi_nxt;
  logic [7:0] hi_map;
  logic       hi_vram;
  logic       reg_hit;
  logic       reg_wr;

  assign reg_hit = (a == REG_ADDR);
  assign reg_wr  = m_tick && cpu_wr && reg_hit;

  oam_dma_addr u_addr (
    .src_hi  (src_hi),
    .hi_map  (hi_map),
    .hi_vram (hi_vram)
  );

  // State register; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic plus the datapath updates that go with each transition.
  // A register write always wins, even on the final RUN tick.
  always_comb begin
    state_nxt  = state;
    src_hi_nxt = src_hi;
    lo_nxt     = lo;
    dma_hi_nxt = dma_hi;
    if (m_tick) begin
      if (reg_wr) begin
        src_hi_nxt = d;
        state_nxt  = ST_PENDING;
      end else begin
        case (state)
          ST_PENDING: begin
            // High byte is latched at start so dma_a holds after the run ends.
            lo_nxt     = 8'h00;
            dma_hi_nxt = hi_map;
            state_nxt  = ST_RUN;
          end
          ST_RUN: begin
            if (lo < LAST_LO) lo_nxt = lo + 8'd1;
            else              state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Source register, byte index and latched address high byte.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      src_hi <= 8'hFF;
      lo     <= 8'h00;
      dma_hi <= 8'hFF;
    end else begin
      src_hi <= src_hi_nxt;
      lo     <= lo_nxt;
      dma_hi <= dma_hi_nxt;
    end
  end

  // Output decode; everything is derived from registered state.
  always_comb begin
    dma_run       = (state == ST_RUN);
    vram_to_oam   = dma_run && hi_vram;
    oam_addr_ndma = !dma_run;
    dma_a         = {dma_hi, lo};
    dma_oam_wr    = dma_run && m_tick;
    reg_q         = src_hi;
    reg_rd_en     = cpu_rd && reg_hit;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed testbench for oam_dma.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        m_tick = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  reg_q;
  logic        reg_rd_en;
  logic        dma_run;
  logic        vram_to_oam;
  logic        oam_addr_ndma;
  logic [15:0] dma_a;
  logic        dma_oam_wr;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  oam_dma dut (
    .clk           (clk),
    .nreset        (nreset),
    .m_tick        (m_tick),
    .a             (a),
    .d             (d),
    .cpu_wr        (cpu_wr),
    .cpu_rd        (cpu_rd),
    .reg_q         (reg_q),
    .reg_rd_en     (reg_rd_en),
    .dma_run       (dma_run),
    .vram_to_oam   (vram_to_oam),
    .oam_addr_ndma (oam_addr_ndma),
    .dma_a         (dma_a),
    .dma_oam_wr    (dma_oam_wr)
  );

  always #5 clk = ~clk;

  // Count OAM write pulses seen at each clock edge.
  always @(posedge clk) if (dma_oam_wr === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One M-cycle: m_tick high for one clock edge, then one idle clock.
  task automatic step();
    m_tick = 1'b1;
    @(posedge clk); #1;
    m_tick = 1'b0;
    cpu_wr = 1'b0;
    a      = 16'h0000;
    @(posedge clk); #1;
  endtask

  // Register write to FF46 on the next M-cycle tick.
  task automatic wr46(input logic [7:0] v);
    a = 16'hFF46; d = v; cpu_wr = 1'b1;
    step();
  endtask

  // Full uninterrupted transfer with per-byte address and VRAM flag checks.
  task automatic run_xfer(input logic [7:0] hi, input logic [7:0] exp_hi, input logic exp_vram);
    int c0;
    c0 = wr_cnt;
    wr46(hi);
    chk("pending_run", dma_run, 0);
    step();
    for (int i = 0; i < 160; i++) begin
      chk("run", dma_run, 1);
      chk("dma_a", dma_a, {exp_hi, 8'(i)});
      chk("vram", vram_to_oam, exp_vram);
      step();
    end
    chk("run_end", dma_run, 0);
    chk("a_hold", dma_a, {exp_hi, 8'h9F});
    chk("wr_count", wr_cnt - c0, 160);
  endtask

  initial begin
    int c0;
    #12;
    // Reset values
    chk("rst_run", dma_run, 0);
    chk("rst_ndma", oam_addr_ndma, 1);
    chk("rst_a", dma_a, 16'hFF00);
    chk("rst_regq", reg_q, 8'hFF);
    chk("rst_vram", vram_to_oam, 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Basic transfer: latency N+2, 160 bytes from C100
    run_xfer(8'hC1, 8'hC1, 1'b0);
    // VRAM source and a just-outside-VRAM source
    run_xfer(8'h80, 8'h80, 1'b1);
    run_xfer(8'hA0, 8'hA0, 1'b0);
    // Echo remap
    run_xfer(8'hFE, 8'hDE, 1'b0);
    cpu_rd = 1'b1; a = 16'hFF46; #1;
    chk("rd_en", reg_rd_en, 1);
    chk("reg_q", reg_q, 8'hFE);
    a = 16'hFF47; #1;
    chk("rd_en_miss", reg_rd_en, 0);
    cpu_rd = 1'b0; a = 16'h0000;

    // Restart mid-transfer at lo=0x50
    c0 = wr_cnt;
    wr46(8'hC0);
    step();
    for (int i = 0; i < 'h50; i++) step();
    chk("rs_a50", dma_a, 16'hC050);
    wr46(8'hD0);
    chk("rs_gap", dma_run, 0);
    step();
    chk("rs_start", dma_a, 16'hD000);
    chk("rs_run", dma_run, 1);
    for (int i = 0; i < 160; i++) step();
    chk("rs_end", dma_run, 0);
    chk("rs_a_end", dma_a, 16'hD09F);
    chk("rs_count", wr_cnt - c0, 241);

    // Write colliding with the last RUN tick
    wr46(8'hC1);
    step();
    for (int i = 0; i < 159; i++) step();
    chk("col_a9f", dma_a, 16'hC19F);
    chk("col_run", dma_run, 1);
    wr46(8'hC2);
    chk("col_pend", dma_run, 0);
    step();
    chk("col_restart", dma_run, 1);
    chk("col_a", dma_a, 16'hC200);
    for (int i = 0; i < 160; i++) step();
    chk("col_end", dma_run, 0);

    // Asynchronous reset at lo=0x30
    wr46(8'hC3);
    step();
    for (int i = 0; i < 'h30; i++) step();
    chk("ar_a30", dma_a, 16'hC330);
    #2 nreset = 1'b0;
    #1;
    chk("ar_run", dma_run, 0);
    chk("ar_ndma", oam_addr_ndma, 1);
    chk("ar_regq", reg_q, 8'hFF);
    chk("ar_a", dma_a, 16'hFF00);
    @(posedge clk); #2 nreset = 1'b1;
    @(posedge clk); #1;
    c0 = wr_cnt;
    for (int i = 0; i < 10; i++) step();
    chk("ar_nowr", wr_cnt - c0, 0);
    chk("ar_idle", dma_run, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
